// File: rtl/serial_rx_sched_pkg.sv
// Shared types and constants for the serial receiver scheduler.
// Holds the FSM encoding, round-robin pointer width and end-time width.
package serial_rx_sched_pkg;

    localparam int RR_PTR_W = 2;
    localparam int TEND_W   = 41;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    // A zero-valued configuration field means "1" to the receiver.
    function automatic logic [31:0] nz32(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic logic [7:0] nz8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter: searches upward starting one past the pointer,
// returning a one-hot pick, its index and a valid flag.
module rr_arb4
    import serial_rx_sched_pkg::*;
(
    input  logic [3:0]          i_req,
    input  logic [RR_PTR_W-1:0] i_ptr,
    output logic [3:0]          o_pick,
    output logic [RR_PTR_W-1:0] o_idx,
    output logic                o_valid
);

    logic [RR_PTR_W-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = i_ptr + RR_PTR_W'(k);
            if (!o_valid && i_req[w_cand]) begin
                o_valid        = 1'b1;
                o_idx          = w_cand;
                o_pick[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_rx_sched.sv
// Round-robin scheduler that grants one requester at a time to a shared serial
// receiver, drives its configuration and timebase, and captures the result.
module serial_rx_sched
    import serial_rx_sched_pkg::*;
#(
    parameter int P_NREQ       = 4,
    parameter int P_DATA_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_NREQ-1:0]       req,
    input  logic [P_NREQ*8-1:0]     cfg_nbits,
    input  logic [P_NREQ*32-1:0]    cfg_n0,
    input  logic [P_NREQ*32-1:0]    cfg_n1,
    output logic [P_NREQ-1:0]       gnt,
    output logic [7:0]              rx_nbits,
    output logic [31:0]             rx_n0,
    output logic [31:0]             rx_n1,
    output logic [31:0]             rx_cnt,
    output logic                    rx_clr,
    input  logic [P_DATA_WIDTH-1:0] rx_data,
    output logic [P_DATA_WIDTH-1:0] dout,
    output logic                    done,
    output logic [1:0]              done_id,
    output logic                    err,
    output logic                    busy
);

    state_t                  r_state, w_next;
    logic [RR_PTR_W-1:0]     r_ptr, r_idx, w_idx;
    logic [3:0]              w_pick;
    logic                    w_valid;
    logic [P_NREQ-1:0]       r_gnt;
    logic [7:0]              r_nbits, w_nbits;
    logic [31:0]             r_n0, r_n1, w_n0, w_n1;
    logic [31:0]             r_cnt;
    logic [TEND_W-1:0]       r_tend, w_tend;
    logic                    w_ovf, w_held, w_end;
    logic [P_DATA_WIDTH-1:0] r_dout;
    logic                    r_err;
    logic [1:0]              r_done_id;

    rr_arb4 u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // Candidate configuration and end time for the requester picked this cycle.
    assign w_nbits = nz8(cfg_nbits[{w_idx, 3'b000} +: 8]);
    assign w_n0    = nz32(cfg_n0[{w_idx, 5'b00000} +: 32]);
    assign w_n1    = nz32(cfg_n1[{w_idx, 5'b00000} +: 32]);
    assign w_tend  = TEND_W'(w_n0) + TEND_W'(w_nbits) * TEND_W'(w_n1);
    // T_end+1 must fit the 32-bit timebase, so T_end itself must stay below 2^32-1.
    assign w_ovf   = (w_tend >= TEND_W'(33'h0_FFFF_FFFF));

    assign w_held  = |(req & r_gnt);
    assign w_end   = ({{(TEND_W-32){1'b0}}, r_cnt} == (r_tend + TEND_W'(1)));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_valid && !w_ovf) w_next = ST_LOAD;
            ST_LOAD:  w_next = w_held ? ST_RUN : ST_ABORT;
            ST_RUN: begin
                if (!w_held)    w_next = ST_ABORT;
                else if (w_end) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= RR_PTR_W'(3);
            r_idx     <= '0;
            r_gnt     <= '0;
            r_nbits   <= 8'd1;
            r_n0      <= 32'd1;
            r_n1      <= 32'd1;
            r_tend    <= '0;
            r_cnt     <= 32'd0;
            r_dout    <= '0;
            r_err     <= 1'b0;
            r_done_id <= 2'd0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            r_cnt   <= (r_state == ST_RUN && w_next == ST_RUN) ? r_cnt + 32'd1 : 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid && w_ovf) begin
                        r_err     <= 1'b1;
                        r_done_id <= w_idx;
                        r_ptr     <= w_idx;
                    end else if (w_valid) begin
                        r_gnt   <= w_pick;
                        r_idx   <= w_idx;
                        r_nbits <= w_nbits;
                        r_n0    <= w_n0;
                        r_n1    <= w_n1;
                        r_tend  <= w_tend;
                    end
                end
                ST_RUN: begin
                    if (w_next == ST_DONE) begin
                        r_dout    <= rx_data;
                        r_done_id <= r_idx;
                    end
                end
                ST_DONE, ST_ABORT: r_ptr <= r_idx;
                default: ;
            endcase
            if (w_next == ST_ABORT || w_next == ST_IDLE)
                r_gnt <= '0;
        end
    end

    assign gnt      = r_gnt;
    assign rx_nbits = r_nbits;
    assign rx_n0    = r_n0;
    assign rx_n1    = r_n1;
    assign rx_cnt   = r_cnt;
    assign rx_clr   = rst | (r_state == ST_LOAD) | (r_state == ST_ABORT);
    assign dout     = r_dout;
    assign done     = (r_state == ST_DONE);
    assign done_id  = r_done_id;
    assign err      = r_err;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_sched.sv
// Directed bench for serial_rx_sched: reset, single and round-robin transactions,
// zero-config substitution, overflow rejection, abort and mid-run reset.
module tb_serial_rx_sched;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  cfg_nbits;
    logic [127:0] cfg_n0;
    logic [127:0] cfg_n1;
    logic [3:0]   gnt;
    logic [7:0]   rx_nbits;
    logic [31:0]  rx_n0, rx_n1, rx_cnt;
    logic         rx_clr;
    logic [255:0] rx_data;
    logic [255:0] dout;
    logic         done;
    logic [1:0]   done_id;
    logic         err;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [255:0] exp_dout = '0;

    serial_rx_sched #(.P_NREQ(4), .P_DATA_WIDTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cfg_nbits (cfg_nbits),
        .cfg_n0    (cfg_n0),
        .cfg_n1    (cfg_n1),
        .gnt       (gnt),
        .rx_nbits  (rx_nbits),
        .rx_n0     (rx_n0),
        .rx_n1     (rx_n1),
        .rx_cnt    (rx_cnt),
        .rx_clr    (rx_clr),
        .rx_data   (rx_data),
        .dout      (dout),
        .done      (done),
        .done_id   (done_id),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int id, input logic [7:0] nb, input logic [31:0] n0, input logic [31:0] n1);
        cfg_nbits[id*8 +: 8] = nb;
        cfg_n0[id*32 +: 32]  = n0;
        cfg_n1[id*32 +: 32]  = n1;
    endtask

    // Waits for a grant, checks the grant cycle, then times the done pulse.
    task automatic run_txn(input int id, input logic [7:0] nb, input logic [31:0] n0,
                           input logic [31:0] n1, input int tend, input logic [255:0] data);
        int cyc;
        rx_data = data;
        cyc = 0;
        do begin wait_cycle(); cyc++; end while (gnt == 4'b0 && cyc < 20);
        n_total++;
        if (gnt !== 4'(1 << id)) $display("FAIL grant_%0d: got %b expected %b", id, gnt, 4'(1 << id));
        else n_pass++;
        n_total++;
        if ({rx_clr, rx_cnt, rx_nbits, rx_n0, rx_n1} !== {1'b1, 32'd0, nb, n0, n1})
            $display("FAIL load_cfg_%0d: got clr=%b cnt=%0d cfg=%0d/%0h/%0h expected clr=1 cnt=0 cfg=%0d/%0h/%0h",
                     id, rx_clr, rx_cnt, rx_nbits, rx_n0, rx_n1, nb, n0, n1);
        else n_pass++;
        cyc = 0;
        do begin wait_cycle(); cyc++; end while (done !== 1'b1 && cyc < tend + 20);
        n_total++;
        if (cyc !== tend + 3) $display("FAIL latency_%0d: got %0d expected %0d", id, cyc, tend + 3);
        else n_pass++;
        exp_dout = data;
        n_total++;
        if (done_id !== 2'(id) || dout !== data)
            $display("FAIL result_%0d: got id=%0d dout=%h expected id=%0d dout=%h", id, done_id, dout, id, data);
        else n_pass++;
    endtask

    task automatic test_reset();
        wait_cycle();
        wait_cycle();
        n_total++;
        if ({gnt, done, err, busy, rx_clr, done_id} !== {4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0})
            $display("FAIL reset_ctl: got gnt=%b done=%b err=%b busy=%b clr=%b id=%0d expected 0000/0/0/0/1/0",
                     gnt, done, err, busy, rx_clr, done_id);
        else n_pass++;
        n_total++;
        if ({rx_nbits, rx_n0, rx_n1} !== {8'd1, 32'd1, 32'd1})
            $display("FAIL reset_cfg: got %0d/%0d/%0d expected 1/1/1", rx_nbits, rx_n0, rx_n1);
        else n_pass++;
        n_total++;
        if (rx_cnt !== 32'd0 || dout !== 256'd0)
            $display("FAIL reset_data: got cnt=%0d dout=%h expected 0/0", rx_cnt, dout);
        else n_pass++;
        rst = 1'b0;
        wait_cycle();
        n_total++;
        if (rx_clr !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_reset: got clr=%b busy=%b expected 0/0", rx_clr, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        set_cfg(0, 8'd8, 32'd4, 32'd2);
        req = 4'b0001;
        run_txn(0, 8'd8, 32'd4, 32'd2, 20, {8{32'hA5A5_0001}});
        req = 4'b0000;
        wait_cycle();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int tends [4] = '{3, 5, 8, 11};
        rst = 1'b1;
        wait_cycle();
        rst = 1'b0;
        wait_cycle();
        for (int i = 0; i < 4; i++) set_cfg(i, 8'(i + 1), 32'(i), 32'd2);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_txn(order[k], 8'(order[k] + 1), (order[k] == 0) ? 32'd1 : 32'(order[k]), 32'd2,
                    tends[order[k]], {8{32'h1000_0000 + 32'(k)}});
        end
        req = 4'b0000;
        wait_cycle();
    endtask

    task automatic test_zero_cfg();
        set_cfg(2, 8'd0, 32'd0, 32'd0);
        req = 4'b0100;
        run_txn(2, 8'd1, 32'd1, 32'd1, 2, {8{32'h2222_0002}});
        req = 4'b0000;
        wait_cycle();
    endtask

    task automatic ovf_case(input int id, input logic [7:0] nb, input logic [31:0] n0, input logic [31:0] n1);
        set_cfg(id, nb, n0, n1);
        req = 4'(1 << id);
        wait_cycle();
        n_total++;
        if ({err, done_id, gnt, rx_clr, busy} !== {1'b1, 2'(id), 4'b0, 1'b0, 1'b0})
            $display("FAIL ovf_pulse_%0d: got err=%b id=%0d gnt=%b clr=%b busy=%b expected 1/%0d/0000/0/0",
                     id, err, done_id, gnt, rx_clr, busy, id);
        else n_pass++;
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            wait_cycle();
            n_total++;
            if ({err, gnt, rx_clr, busy} !== 7'b0)
                $display("FAIL ovf_after_%0d: got err=%b gnt=%b clr=%b busy=%b expected all 0",
                         id, err, gnt, rx_clr, busy);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int cyc;
        ovf_case(3, 8'd255, 32'd1, 32'h0200_0000);
        ovf_case(1, 8'd1, 32'hFFFF_FFFE, 32'd1);
        // Largest legal end time: granted, then released to abort.
        set_cfg(1, 8'd1, 32'hFFFF_FFFD, 32'd1);
        req = 4'b0010;
        cyc = 0;
        do begin wait_cycle(); cyc++; end while (gnt == 4'b0 && cyc < 10);
        n_total++;
        if ({err, gnt, rx_n0} !== {1'b0, 4'b0010, 32'hFFFF_FFFD})
            $display("FAIL ovf_boundary: got err=%b gnt=%b n0=%h expected 0/0010/fffffffd", err, gnt, rx_n0);
        else n_pass++;
        req = 4'b0000;
        wait_cycle();
        n_total++;
        if ({rx_clr, gnt, done} !== {1'b1, 4'b0, 1'b0})
            $display("FAIL boundary_abort: got clr=%b gnt=%b done=%b expected 1/0000/0", rx_clr, gnt, done);
        else n_pass++;
        wait_cycle();
    endtask

    task automatic test_abort();
        int cyc;
        set_cfg(1, 8'd8, 32'd100, 32'd1);
        rx_data = {8{32'h3333_0003}};
        req = 4'b0010;
        cyc = 0;
        do begin wait_cycle(); cyc++; end while (gnt == 4'b0 && cyc < 10);
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL abort_grant: got %b expected 0010", gnt);
        else n_pass++;
        req = 4'b0110;
        cfg_n0[1*32 +: 32] = 32'd7;
        cyc = 0;
        while (rx_cnt != 32'd5 && cyc < 30) begin wait_cycle(); cyc++; end
        n_total++;
        if ({rx_cnt, gnt, rx_n0} !== {32'd5, 4'b0010, 32'd100})
            $display("FAIL abort_hold: got cnt=%0d gnt=%b n0=%0d expected 5/0010/100", rx_cnt, gnt, rx_n0);
        else n_pass++;
        req = 4'b0100;
        wait_cycle();
        n_total++;
        if ({rx_clr, gnt, done, busy} !== {1'b1, 4'b0, 1'b0, 1'b1})
            $display("FAIL abort_state: got clr=%b gnt=%b done=%b busy=%b expected 1/0000/0/1",
                     rx_clr, gnt, done, busy);
        else n_pass++;
        n_total++;
        if (dout !== exp_dout) $display("FAIL abort_dout: got %h expected %h", dout, exp_dout);
        else n_pass++;
        run_txn(2, 8'd1, 32'd1, 32'd1, 2, {8{32'h4444_0004}});
        req = 4'b0000;
        wait_cycle();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        set_cfg(0, 8'd4, 32'd50, 32'd1);
        req = 4'b0001;
        cyc = 0;
        while (!(busy && rx_cnt == 32'd10) && cyc < 40) begin wait_cycle(); cyc++; end
        n_total++;
        if ({rx_cnt, gnt} !== {32'd10, 4'b0001})
            $display("FAIL midrun_reach: got cnt=%0d gnt=%b expected 10/0001", rx_cnt, gnt);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({gnt, rx_cnt, busy, done, err, rx_clr, done_id, rx_nbits, rx_n0, rx_n1} !==
            {4'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1, 32'd1, 32'd1})
            $display("FAIL midrun_reset: got gnt=%b cnt=%0d busy=%b done=%b err=%b clr=%b id=%0d cfg=%0d/%0d/%0d",
                     gnt, rx_cnt, busy, done, err, rx_clr, done_id, rx_nbits, rx_n0, rx_n1);
        else n_pass++;
        n_total++;
        if (dout !== 256'd0) $display("FAIL midrun_dout: got %h expected 0", dout);
        else n_pass++;
        set_cfg(0, 8'd1, 32'd1, 32'd1);
        req = 4'b1111;
        wait_cycle();
        wait_cycle();
        rst = 1'b0;
        wait_cycle();
        n_total++;
        if ({gnt, done} !== {4'b0001, 1'b0})
            $display("FAIL post_reset_pick: got gnt=%b done=%b expected 0001/0", gnt, done);
        else n_pass++;
        req = 4'b0000;
        wait_cycle();
        wait_cycle();
        wait_cycle();
        n_total++;
        if ({busy, gnt} !== 5'b0) $display("FAIL final_idle: got busy=%b gnt=%b expected 0/0000", busy, gnt);
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0;
        cfg_nbits = '0;
        cfg_n0    = '0;
        cfg_n1    = '0;
        rx_data   = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_zero_cfg();
        test_overflow();
        test_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
